// File: rtl/rf_alu_sequencer.sv
// Sequencer for a shared register-file + ALU datapath: accept one instruction,
// execute, write back, then hold the response until the consumer takes it.
module rf_alu_sequencer #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned CNT_W        = 16,
  parameter bit          ZERO_PROTECT = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic              in_imm_en,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic [DATA_W-1:0] in_imm,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_rd,
  output logic [ADDR_W-1:0] rf_a1,
  output logic [ADDR_W-1:0] rf_a2,
  output logic [ADDR_W-1:0] rf_a3,
  output logic [DATA_W-1:0] rf_wd3,
  output logic              rf_we3,
  output logic [1:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  output logic              busy,
  output logic [CNT_W-1:0]  retire_count
);

  typedef enum logic [1:0] {IDLE, EXEC, WB, RESP} state_t;

  typedef struct packed {
    logic [1:0]        op;
    logic              imm_en;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [DATA_W-1:0] imm;
  } instr_t;

  state_t            state_q, state_d;
  instr_t            instr_q, instr_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [CNT_W-1:0]  retire_q, retire_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      instr_q  <= '0;
      result_q <= '0;
      retire_q <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      result_q <= result_d;
      retire_q <= retire_d;
    end
  end

  // Outputs decode the state register directly, so reset kills the write
  // enable the moment RST rises.
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    result_d   = result_q;
    retire_d   = retire_q;
    in_ready   = 1'b0;
    busy       = 1'b1;
    rsp_valid  = 1'b0;
    rf_a1      = '0;
    rf_a2      = '0;
    rf_a3      = '0;
    rf_wd3     = '0;
    rf_we3     = 1'b0;
    alu_opcode = '0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          instr_d.op     = in_op;
          instr_d.imm_en = in_imm_en;
          instr_d.rd     = in_rd;
          instr_d.rs1    = in_rs1;
          instr_d.rs2    = in_rs2;
          instr_d.imm    = in_imm;
          state_d        = EXEC;
        end
      end
      EXEC: begin
        rf_a1      = instr_q.rs1;
        rf_a2      = instr_q.rs2;
        alu_opcode = instr_q.op;
        result_d   = instr_q.imm_en ? instr_q.imm : alu_result;
        state_d    = WB;
      end
      WB: begin
        rf_a3     = instr_q.rd;
        rf_wd3    = result_q;
        rf_we3    = !(ZERO_PROTECT && (instr_q.rd == '0));
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          retire_d = retire_q + CNT_W'(1);
          state_d  = IDLE;
        end else begin
          state_d  = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          retire_d = retire_q + CNT_W'(1);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_data     = result_q;
  assign rsp_rd       = instr_q.rd;
  assign retire_count = retire_q;

endmodule

// File: doc/rf_alu_sequencer.md
# rf_alu_sequencer

Controller that sequences the shared register-file + ALU datapath. It accepts one instruction at a time over a valid/ready port, drives register-file read addresses and the ALU opcode, captures the ALU result (or an immediate), writes it back, and returns the result over a valid/ready response port. It sits between an instruction source and the register-file/ALU pair, and owns every register-file control pin.

## Interface
- DATA_W, 32, datapath and register width
- ADDR_W, 5, register address width
- CNT_W, 16, retire counter width
- ZERO_PROTECT, 1, when 1 writes to register 0 are suppressed (WE3 held low; response still returned)

- CLK  input  1  clock, all state updates on rising edge
- RST  input  1  asynchronous, active-high reset
- in_valid  input  1  instruction offered
- in_ready  output  1  sequencer can accept (high only in IDLE)
- in_op  input  2  ALU opcode
- in_imm_en  input  1  1 = load immediate, ALU bypassed
- in_rd / in_rs1 / in_rs2  input  ADDR_W each  destination / source registers
- in_imm  input  DATA_W  immediate value
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer accepts result
- rsp_data  output  DATA_W  written-back value
- rsp_rd  output  ADDR_W  destination of that value
- rf_a1 / rf_a2 / rf_a3  output  ADDR_W each  register-file read/write addresses
- rf_wd3  output  DATA_W  register-file write data
- rf_we3  output  1  register-file write enable
- alu_opcode  output  2  ALU opcode
- alu_result  input  DATA_W  combinational ALU result
- busy  output  1  high in any state except IDLE
- retire_count  output  CNT_W  responses accepted since reset

## Operation
- States: IDLE, EXEC, WB, RESP.
- IDLE: in_ready=1. On in_valid, latch op/imm_en/rd/rs1/rs2/imm, go EXEC.
- EXEC: drive rf_a1=rs1, rf_a2=rs2, alu_opcode=op from latched fields. Register-file reads are combinational. On the edge leaving EXEC, capture result = imm_en ? imm : alu_result. Go WB.
- WB: rf_a3=rd, rf_wd3=captured result, rf_we3=1 (0 if ZERO_PROTECT and rd==0). rsp_valid=1. If rsp_ready, go IDLE and increment retire_count; else go RESP.
- RESP: rsp_valid=1, rf_we3=0. On rsp_ready, go IDLE and increment retire_count.
- rf_we3 is high for exactly one cycle per instruction, in WB only, never repeated during RESP stalls.
- rsp_data/rsp_rd hold the captured value from WB until the handshake completes, and are stable while rsp_valid=1 and rsp_ready=0.
- Outside EXEC: rf_a1, rf_a2, alu_opcode = 0. Outside WB: rf_a3, rf_wd3 = 0.
- retire_count wraps modulo 2^CNT_W.
- Read-after-write across instructions is safe by construction: the WB write lands before the next EXEC read.
- An instruction with rs1 or rs2 equal to the previous rd reads the new value.

## Timing
- Reset (async, immediate): state IDLE, in_ready=1, busy=0, rsp_valid=0, rf_we3=0, all address/data/opcode outputs 0, retire_count=0, latched fields 0.
- Reset asserted mid-instruction aborts it. rf_we3 drops combinationally with RST, no write occurs, and the pending response is discarded.
- Accept at edge T0. EXEC during cycle T0→T1. WB/rsp_valid during T1→T2, with the register-file write at edge T2.
- Minimum issue interval is 3 cycles with rsp_ready held high.
- Each cycle of rsp_ready=0 adds one cycle of RESP.
- in_valid is ignored while busy. Offered fields need only be stable in the accepting IDLE cycle.

## Test plan
- Reset, then in_imm_en=1, rd=3, imm=0x0000_00AA -> rf_we3 pulses one cycle 2 edges after accept with rf_a3=3, rf_wd3=0xAA; rsp_data=0xAA, rsp_rd=3; retire_count=1.
- Load r1=5 and r2=7 as immediates, then in_op=2'b00 (ADD in the bench ALU model), rs1=1, rs2=2, rd=4 -> rf_a1=1, rf_a2=2 during EXEC; rsp_data=12; r4=12 in the register-file model.
- Hold rsp_ready=0 for 4 cycles after WB -> rsp_valid stays high with rsp_data stable, rf_we3 is high only in the WB cycle, in_ready=0 throughout, and the next instruction is accepted the cycle after the handshake.
- ZERO_PROTECT=1, immediate 0x1234 to rd=0 -> rf_we3 stays 0, r0 is unchanged, rsp_data=0x1234 and rsp_rd=0 are still returned, and retire_count increments.
- Assert RST during the EXEC and WB cycles -> rf_we3 drops immediately, the destination register is unchanged, rsp_valid=0, retire_count=0, and the sequencer is in IDLE with in_ready=1 after release.
- Back-to-back chain (r5=r5+r5, 3 times, from r5=1) with rsp_ready=1 -> accepts spaced exactly 3 cycles apart, responses 2, 4, 8.
